// File: rtl/neopixel_pkg.sv
// neopixel_pkg: shared state encoding and default timing constants for the NeoPixel receiver.
package neopixel_pkg;
    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} dec_state_t;
    localparam int NEO_RST_CYC = 4000;
    localparam int NEO_HIGH_MAX_CYC = 255;
endpackage

// File: rtl/neopixel_decoder_sync_edge.sv
// sync_edge: 2-flop synchronizer plus delay flop; edge pulses are derived from the synchronized level.
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);
    logic meta, dly;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= 1'b0;
            s    <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= din;
            s    <= meta;
            dly  <= s;
        end
    end
    assign rise = s & ~dly;
    assign fall = ~s & dly;
endmodule

// File: rtl/neopixel_decoder.sv
// neopixel_decoder: classifies high-pulse widths into bits, packs MSB-first bytes, detects latch and framing errors.
module neopixel_decoder
    import neopixel_pkg::*;
#(
    parameter int RST_CYC      = NEO_RST_CYC,
    parameter int HIGH_MAX_CYC = NEO_HIGH_MAX_CYC,
    parameter int LEN_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bit_code_i,
    input  logic [7:0]       reg_thr_time_i,
    output logic             byte_vld_o,
    output logic [7:0]       byte_data_o,
    output logic             frame_done_o,
    output logic [LEN_W-1:0] frame_len_o,
    output logic             bit_err_o
);
    localparam int LW = $clog2(RST_CYC + 1);
    localparam logic [LW-1:0] LCNT_MAX = LW'(RST_CYC);
    localparam logic [8:0] HMAX = 9'(HIGH_MAX_CYC);

    dec_state_t state, state_n;
    logic [LW-1:0] lcnt, lcnt_n;
    logic [7:0] hcnt, hcnt_n, sreg, sreg_n, data_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [LEN_W-1:0] flen, flen_n, len_n;
    logic vld_n, done_n, err_n, bit_v;
    logic s, rise, fall;

    sync_edge u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .din  (bit_code_i),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_n  = state;
        lcnt_n   = lcnt;
        hcnt_n   = hcnt;
        sreg_n   = sreg;
        bitcnt_n = bitcnt;
        flen_n   = flen;
        data_n   = byte_data_o;
        len_n    = frame_len_o;
        vld_n    = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        bit_v    = hcnt >= reg_thr_time_i;
        unique case (state)
            SYNC: begin
                if (s) lcnt_n = '0;
                else if (lcnt == LCNT_MAX) state_n = IDLE;
                else lcnt_n = lcnt + 1'b1;
            end
            IDLE: begin
                if (rise) begin
                    state_n = HIGH;
                    hcnt_n  = 8'd1;
                end
            end
            HIGH: begin
                if (fall) begin
                    sreg_n   = {sreg[6:0], bit_v};
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 3'd7) begin
                        data_n = {sreg[6:0], bit_v};
                        vld_n  = 1'b1;
                        flen_n = &flen ? flen : flen + 1'b1;
                    end
                    state_n = LOW;
                    lcnt_n  = LW'(1);
                end else if ({1'b0, hcnt} + 9'd1 == HMAX) begin
                    // over-long pulse: drop the frame and demand a fresh latch-length low
                    err_n    = 1'b1;
                    sreg_n   = '0;
                    bitcnt_n = '0;
                    flen_n   = '0;
                    lcnt_n   = '0;
                    state_n  = SYNC;
                end else begin
                    hcnt_n = &hcnt ? hcnt : hcnt + 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_n = HIGH;
                    hcnt_n  = 8'd1;
                end else if (lcnt == LCNT_MAX) begin
                    err_n    = bitcnt != 3'd0;
                    done_n   = 1'b1;
                    len_n    = flen;
                    flen_n   = '0;
                    bitcnt_n = '0;
                    sreg_n   = '0;
                    state_n  = IDLE;
                end else begin
                    lcnt_n = lcnt + 1'b1;
                end
            end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= SYNC;
            lcnt         <= '0;
            hcnt         <= '0;
            sreg         <= '0;
            bitcnt       <= '0;
            flen         <= '0;
            byte_vld_o   <= 1'b0;
            byte_data_o  <= '0;
            frame_done_o <= 1'b0;
            frame_len_o  <= '0;
            bit_err_o    <= 1'b0;
        end else begin
            state        <= state_n;
            lcnt         <= lcnt_n;
            hcnt         <= hcnt_n;
            sreg         <= sreg_n;
            bitcnt       <= bitcnt_n;
            flen         <= flen_n;
            byte_vld_o   <= vld_n;
            byte_data_o  <= data_n;
            frame_done_o <= done_n;
            frame_len_o  <= len_n;
            bit_err_o    <= err_n;
        end
    end
endmodule
